pdm_audio_sequencer: RTL and testbench

PDM_AUDIO_SEQUENCER -- requirements
Module: pdm_audio_sequencer

---
 rtl/pdm_audio_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pdm_audio_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_audio_sequencer.sv
// Sample FIFO plus IDLE/FILL/RUN/DRAIN sequencer that paces signed levels to a PDM modulator.
// Define PDM_SEQ_UNDERRUN_CNT_EN to add the saturating underrun_count_out event counter.
module pdm_audio_sequencer #(
    parameter int TICK_DIV   = 4,
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic signed [7:0]             sample_in,
    input  logic                          sample_valid_in,
    output logic                          sample_ready_out,
    output logic signed [7:0]             level_out,
    output logic                          tick_out,
    output logic                          running_out,
    output logic                          underrun_out,
`ifdef PDM_SEQ_UNDERRUN_CNT_EN
    output logic [15:0]                   underrun_count_out,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(OSR);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SMP_LAST  = SW'(OSR - 1);
    localparam logic [CW-1:0] FILL_MARK = CW'(FIFO_DEPTH / 2);
    localparam logic [CW-1:0] FULL_MARK = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

    state_t            state_q;
    state_t            state_d;

    logic signed [7:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop_req;
    logic              pop;

    logic [TW-1:0]     tick_cnt;
    logic [SW-1:0]     smp_cnt;
    logic              running;
    logic              tick;
    logic              smp_strobe;
    logic              cnt_adv;

    logic              level_zero;
    logic              underrun_d;
    logic signed [7:0] level_p1;
    logic              underrun_p1;

    assign fifo_full  = (fifo_cnt == FULL_MARK);
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = sample_valid_in && !fifo_full;
    // No bypass: a pop only sees what was stored before this edge.
    assign pop        = pop_req && !fifo_empty;

    assign running    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign tick       = running && (tick_cnt == TICK_LAST);
    assign smp_strobe = tick && (smp_cnt == SMP_LAST);
    assign cnt_adv    = running && ((state_d == S_RUN) || (state_d == S_DRAIN));

    always_comb begin
        state_d    = state_q;
        pop_req    = 1'b0;
        level_zero = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_in) state_d = S_FILL;
            end
            S_FILL: begin
                if (!enable_in) begin
                    state_d = S_IDLE;
                end else if (fifo_cnt >= FILL_MARK) begin
                    state_d = S_RUN;
                    pop_req = 1'b1;
                end
            end
            S_RUN: begin
                if (smp_strobe && fifo_empty) begin
                    state_d    = S_FILL;
                    level_zero = 1'b1;
                    underrun_d = 1'b1;
                end else begin
                    pop_req = smp_strobe;
                    if (!enable_in) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (smp_strobe && fifo_empty) begin
                    state_d    = S_IDLE;
                    level_zero = 1'b1;
                end else begin
                    pop_req = smp_strobe;
                    if (enable_in) state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage p1: registered sequencer state, FIFO pointers, cadence counters and outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            tick_cnt    <= '0;
            smp_cnt     <= '0;
            level_p1    <= '0;
            underrun_p1 <= 1'b0;
        end else begin
            state_q     <= state_d;
            underrun_p1 <= underrun_d;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (!cnt_adv) begin
                tick_cnt <= '0;
                smp_cnt  <= '0;
            end else if (tick) begin
                tick_cnt <= '0;
                smp_cnt  <= (smp_cnt == SMP_LAST) ? '0 : smp_cnt + SW'(1);
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
            if (level_zero || (state_d == S_IDLE)) begin
                level_p1 <= '0;
            end else if (pop) begin
                level_p1 <= fifo_mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr] <= sample_in;
    end

`ifdef PDM_SEQ_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            underrun_cnt <= '0;
        end else if (underrun_d) begin
            underrun_cnt <= sat_inc16(underrun_cnt);
        end
    end

    assign underrun_count_out = underrun_cnt;
`endif

    assign sample_ready_out = !fifo_full;
    assign level_out        = level_p1;
    assign tick_out         = tick;
    assign running_out      = running;
    assign underrun_out     = underrun_p1;
    assign fifo_count_out   = fifo_cnt;

endmodule

// File: tb/tb_pdm_audio_sequencer.sv
// Bench for pdm_audio_sequencer (TICK_DIV=4, OSR=4, FIFO_DEPTH=8): queue-based reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_pdm_audio_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int OSR        = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int PER        = TICK_DIV * OSR;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              enable_in;
    logic signed [7:0] sample_in;
    logic              sample_valid_in;
    logic              sample_ready_out;
    logic signed [7:0] level_out;
    logic              tick_out;
    logic              running_out;
    logic              underrun_out;
    logic [3:0]        fifo_count_out;
`ifdef PDM_SEQ_UNDERRUN_CNT_EN
    logic [15:0]       underrun_count_out;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    pdm_audio_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .OSR        (OSR),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .enable_in          (enable_in),
        .sample_in          (sample_in),
        .sample_valid_in    (sample_valid_in),
        .sample_ready_out   (sample_ready_out),
        .level_out          (level_out),
        .tick_out           (tick_out),
        .running_out        (running_out),
        .underrun_out       (underrun_out),
`ifdef PDM_SEQ_UNDERRUN_CNT_EN
        .underrun_count_out (underrun_count_out),
`endif
        .fifo_count_out     (fifo_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of samples plus a phase count of cycles spent playing.
    typedef enum int {M_IDLE, M_FILL, M_RUN, M_DRAIN} mstate_t;
    mstate_t m_st    = M_IDLE;
    int      m_q[$];
    int      m_level = 0;
    int      m_phase = 0;
    bit      m_under = 1'b0;
    bit      m_valid = 1'b0;
    int      m_ucnt  = 0;

    function automatic bit m_playing();
        return (m_st == M_RUN) || (m_st == M_DRAIN);
    endfunction

    always @(posedge clk_in) begin : model_b
        bit pushable;
        bit strobe;
        bit was_play;
        pushable = (m_q.size() < FIFO_DEPTH);
        if (rst_in) begin
            m_q.delete();
            m_st    = M_IDLE;
            m_level = 0;
            m_phase = 0;
            m_under = 1'b0;
            m_ucnt  = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            was_play = m_playing();
            strobe   = was_play && ((m_phase % PER) == PER - 1);
            m_under  = 1'b0;
            case (m_st)
                M_IDLE: if (enable_in) m_st = M_FILL;
                M_FILL: begin
                    if (!enable_in) m_st = M_IDLE;
                    else if (m_q.size() >= FIFO_DEPTH / 2) begin
                        m_level = m_q.pop_front();
                        m_st    = M_RUN;
                    end
                end
                M_RUN: begin
                    if (strobe && m_q.size() == 0) begin
                        m_level = 0;
                        m_under = 1'b1;
                        if (m_ucnt < 65535) m_ucnt++;
                        m_st    = M_FILL;
                    end else begin
                        if (strobe) m_level = m_q.pop_front();
                        if (!enable_in) m_st = M_DRAIN;
                    end
                end
                M_DRAIN: begin
                    if (strobe && m_q.size() == 0) begin
                        m_level = 0;
                        m_st    = M_IDLE;
                    end else begin
                        if (strobe) m_level = m_q.pop_front();
                        if (enable_in) m_st = M_RUN;
                    end
                end
                default: m_st = M_IDLE;
            endcase
            if (sample_valid_in && pushable) m_q.push_back(int'(sample_in));
            if (was_play && m_playing()) m_phase++;
            else m_phase = 0;
        end
    end

    always @(negedge clk_in) begin
        if (m_valid) begin
            chk("model_ready", sample_ready_out, m_q.size() < FIFO_DEPTH);
            chk("model_count", fifo_count_out, m_q.size());
            chk("model_level", level_out, m_level);
            chk("model_tick", tick_out, m_playing() && ((m_phase % TICK_DIV) == TICK_DIV - 1));
            chk("model_running", running_out, m_playing());
            chk("model_underrun", underrun_out, m_under);
`ifdef PDM_SEQ_UNDERRUN_CNT_EN
            chk("model_ucount", underrun_count_out, m_ucnt);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic push_s(input int v);
        sample_in       = v[7:0];
        sample_valid_in = 1'b1;
        cyc(1);
        sample_valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int nt;
        int first_tick;
        int np;
        int nu;
        int n;
        int prev;
        int rec[4];

        rst_in          = 1'b1;
        enable_in       = 1'b0;
        sample_in       = '0;
        sample_valid_in = 1'b0;
        cyc(2);

        // Reset state
        chk("rst_ready", sample_ready_out, 1);
        chk("rst_count", fifo_count_out, 0);
        chk("rst_level", level_out, 0);
        chk("rst_tick", tick_out, 0);
        chk("rst_running", running_out, 0);
        chk("rst_underrun", underrun_out, 0);
        rst_in = 1'b0;
        cyc(1);

        // Fill with 4 samples, enable, first levels and tick cadence
        push_s(10); push_s(20); push_s(30); push_s(40);
        chk("fill_count", fifo_count_out, 4);
        enable_in = 1'b1;
        cyc(2);
        chk("run_entry_running", running_out, 1);
        chk("run_entry_level", level_out, 10);
        chk("run_entry_count", fifo_count_out, 3);
        nt = 0;
        first_tick = -1;
        for (int k = 0; k < 16; k++) begin
            if (tick_out) begin
                nt++;
                if (first_tick < 0) first_tick = k;
            end
            cyc(1);
        end
        chk("first_tick_cycle", first_tick, 3);
        chk("ticks_in_16", nt, 4);
        chk("second_level", level_out, 20);

        // Play out to underrun
        w = 0;
        while (!underrun_out && w < 200) begin
            cyc(1);
            w++;
        end
        chk("underrun_delay", w, 48);
        chk("underrun_level", level_out, 0);
        chk("underrun_running", running_out, 0);
        np = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (underrun_out) np++;
        end
        chk("underrun_single", np, 0);
        enable_in = 1'b0;
        cyc(2);

        // Fill to full, ninth push ignored
        for (int v = 1; v <= 8; v++) push_s(v);
        chk("full_ready", sample_ready_out, 0);
        chk("full_count", fifo_count_out, 8);
        push_s(99);
        chk("full_push_count", fifo_count_out, 8);
        chk("full_push_ready", sample_ready_out, 0);

        // Drop enable with two samples queued
        enable_in = 1'b1;
        cyc(2);
        chk("drain_run_level", level_out, 1);
        w = 0;
        while (fifo_count_out != 2 && w < 300) begin
            cyc(1);
            w++;
        end
        chk("drain_pre_level", level_out, 6);
        enable_in = 1'b0;
        prev = level_out;
        n = 0;
        nu = 0;
        w = 0;
        do begin
            cyc(1);
            w++;
            if (level_out != prev) begin
                if (n < 4) rec[n] = level_out;
                n++;
                prev = level_out;
            end
            if (underrun_out) nu++;
        end while (running_out && w < 300);
        chk("drain_changes", n, 3);
        chk("drain_lvl0", rec[0], 7);
        chk("drain_lvl1", rec[1], 8);
        chk("drain_lvl2", rec[2], 0);
        chk("drain_no_underrun", nu, 0);
        chk("drain_idle", running_out, 0);
        chk("drain_count", fifo_count_out, 0);

        // Simultaneous push/pop on RUN entry, then reset mid-RUN with count 5
        for (int v = -1; v >= -5; v--) push_s(v);
        enable_in = 1'b1;
        cyc(1);
        push_s(-6);
        chk("pushpop_count", fifo_count_out, 5);
        chk("pushpop_level", level_out, -1);
        chk("pushpop_running", running_out, 1);
        cyc(5);
        chk("mid_run_count", fifo_count_out, 5);
        rst_in    = 1'b1;
        enable_in = 1'b0;
        cyc(1);
        rst_in = 1'b0;
        chk("midrst_count", fifo_count_out, 0);
        chk("midrst_level", level_out, 0);
        chk("midrst_tick", tick_out, 0);
        chk("midrst_running", running_out, 0);
        chk("midrst_underrun", underrun_out, 0);
        chk("midrst_ready", sample_ready_out, 1);
        cyc(2);

`ifdef PDM_SEQ_UNDERRUN_CNT_EN
        // Three forced underruns
        enable_in = 1'b1;
        for (int r = 0; r < 3; r++) begin
            push_s(11); push_s(22); push_s(33); push_s(44);
            w = 0;
            while (!underrun_out && w < 200) begin
                cyc(1);
                w++;
            end
            chk("ucnt_underrun_seen", underrun_out, 1);
            cyc(1);
        end
        chk("ucnt_value", underrun_count_out, 3);
        enable_in = 1'b0;
        cyc(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
